// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - byte-addressable data memory with clear-on-reset and edge-strobed writes
// Reads are registered every cycle; writes are taken on a rising mem_clk edge and committed one cycle later.
module data_mem_responder #(
  parameter int ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_clk,
  input  logic [1:0]  mem_size,
  input  logic [31:0] addr,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        busy,
  output logic        err
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {
    CLEAR = 2'b00,
    IDLE  = 2'b01,
    WRITE = 2'b10
  } state_t;

  state_t state, state_next;

  logic                 mem_clk_q;
  logic [ADDR_BITS-1:0] clr_cnt;
  logic [ADDR_BITS+1:0] hold_addr;
  logic [1:0]           hold_size;
  logic [31:0]          hold_data;

  logic [31:0] mem [DEPTH];

  logic                 wr_event;
  logic                 addr_ok;
  logic                 accept;
  logic                 reject;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_idx;
  logic [3:0]           mem_be;
  logic [31:0]          mem_wdata;
  logic [3:0]           commit_be;
  logic [31:0]          rd_word;
  logic [31:0]          rd_shift;
  logic [31:0]          rd_value;

  // Same legality rule for reads and writes: aligned, known size, inside storage.
  function automatic logic access_ok(input logic [1:0] size, input logic [31:0] a);
    logic ok;
    ok = 1'b1;
    case (size)
      2'b01:   if (a[0]) ok = 1'b0;
      2'b10:   if (a[1:0] != 2'b00) ok = 1'b0;
      2'b11:   ok = 1'b0;
      default: ok = 1'b1;
    endcase
    if ((a >> (ADDR_BITS + 2)) != 32'd0) ok = 1'b0;
    return ok;
  endfunction

  assign wr_event = mem_clk & ~mem_clk_q;
  assign addr_ok  = access_ok(mem_size, addr);
  assign busy     = (state != IDLE);

  // Read path sees storage as of the start of the cycle; no forwarding.
  always_comb begin
    rd_word  = mem[addr[ADDR_BITS+1:2]];
    rd_shift = rd_word >> {addr[1:0], 3'b000};
    rd_value = 32'd0;
    if (addr_ok) begin
      case (mem_size)
        2'b00:   rd_value = {24'd0, rd_shift[7:0]};
        2'b01:   rd_value = {16'd0, rd_shift[15:0]};
        default: rd_value = rd_shift;
      endcase
    end
  end

  always_comb begin
    commit_be = 4'b1111;
    case (hold_size)
      2'b00:   commit_be = 4'b0001 << hold_addr[1:0];
      2'b01:   commit_be = hold_addr[1] ? 4'b1100 : 4'b0011;
      default: commit_be = 4'b1111;
    endcase
  end

  always_comb begin
    state_next = state;
    mem_we     = 1'b0;
    mem_idx    = clr_cnt;
    mem_be     = 4'b0000;
    mem_wdata  = 32'd0;
    accept     = 1'b0;
    reject     = 1'b0;
    case (state)
      CLEAR: begin
        mem_we = 1'b1;
        mem_be = 4'b1111;
        reject = wr_event;
        if (clr_cnt == '1) state_next = IDLE;
      end
      IDLE: begin
        if (wr_event) begin
          if (addr_ok) begin
            accept     = 1'b1;
            state_next = WRITE;
          end else begin
            reject = 1'b1;
          end
        end
      end
      WRITE: begin
        mem_we     = 1'b1;
        mem_idx    = hold_addr[ADDR_BITS+1:2];
        mem_be     = commit_be;
        mem_wdata  = hold_data << {hold_addr[1:0], 3'b000};
        state_next = IDLE;
      end
      default: state_next = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= CLEAR;
      clr_cnt   <= '0;
      mem_clk_q <= 1'b0;
      data_o    <= 32'd0;
      err       <= 1'b0;
      hold_addr <= '0;
      hold_size <= 2'b00;
      hold_data <= 32'd0;
    end else begin
      state     <= state_next;
      mem_clk_q <= mem_clk;
      clr_cnt   <= (state == CLEAR) ? clr_cnt + 1'b1 : '0;
      err       <= reject;
      data_o    <= (state == CLEAR) ? 32'd0 : rd_value;
      if (accept) begin
        hold_addr <= addr[ADDR_BITS+1:0];
        hold_size <= mem_size;
        hold_data <= data_i;
      end
    end
  end

  // Reset gates the write port so a commit in flight is dropped.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder
// A byte-array model tracks the small instance every cycle; a second instance covers the wide address range.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, mem_clk, busy, err;
  logic [1:0]  mem_size;
  logic [31:0] addr, data_i, data_o;

  logic        r_reset, r_mem_clk, r_busy, r_err;
  logic [1:0]  r_size;
  logic [31:0] r_addr, r_data, r_data_o;

  data_mem_responder #(.ADDR_BITS(4)) dut (
    .clk(clk), .reset(reset), .mem_clk(mem_clk), .mem_size(mem_size),
    .addr(addr), .data_i(data_i), .data_o(data_o), .busy(busy), .err(err)
  );

  data_mem_responder #(.ADDR_BITS(10)) dut_big (
    .clk(clk), .reset(r_reset), .mem_clk(r_mem_clk), .mem_size(r_size),
    .addr(r_addr), .data_i(r_data), .data_o(r_data_o), .busy(r_busy), .err(r_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: 64 bytes of storage, a clear countdown and at most one pending write.
  logic [7:0]  m_bytes [64];
  int          clear_left = 0;
  bit          pend = 0;
  logic [31:0] pend_addr, pend_data;
  logic [1:0]  pend_size;
  bit          prev_clk = 0;
  bit          model_on = 0;
  logic [31:0] exp_data = 32'd0;
  logic        exp_busy = 1'b1;
  logic        exp_err = 1'b0;

  function automatic bit legal(input logic [1:0] s, input logic [31:0] a);
    if (s == 2'b11) return 0;
    if (s == 2'b01 && a[0]) return 0;
    if (s == 2'b10 && a[1:0] != 2'b00) return 0;
    if (a >= 32'd64) return 0;
    return 1;
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] s, input logic [31:0] a);
    int          base;
    logic [31:0] w;
    if (!legal(s, a)) return 32'd0;
    base = int'(a[5:2]) * 4;
    w = {m_bytes[base+3], m_bytes[base+2], m_bytes[base+1], m_bytes[base]};
    w = w >> (8 * int'(a[1:0]));
    if (s == 2'b00) return w & 32'h0000_00FF;
    if (s == 2'b01) return w & 32'h0000_FFFF;
    return w;
  endfunction

  always @(negedge clk) begin
    bit ev, in_clear, in_write;
    int ia, nb;
    if (model_on) begin
      check("busy", busy, exp_busy);
      check("err", err, exp_err);
      check("data_o", data_o, exp_data);
    end
    if (reset) begin
      model_on   = 1;
      clear_left = 16;
      pend       = 0;
      prev_clk   = 0;
      exp_data   = 32'd0;
      exp_err    = 1'b0;
      exp_busy   = 1'b1;
    end else if (model_on) begin
      in_clear = (clear_left > 0);
      in_write = pend;
      ev       = mem_clk && !prev_clk;
      prev_clk = mem_clk;
      exp_data = in_clear ? 32'd0 : model_read(mem_size, addr);
      exp_err  = ev && (in_clear || (!in_write && !legal(mem_size, addr)));
      if (in_write) begin
        ia = int'(pend_addr[5:0]);
        nb = (pend_size == 2'b00) ? 1 : (pend_size == 2'b01) ? 2 : 4;
        for (int k = 0; k < nb; k++) m_bytes[ia+k] = pend_data[8*k +: 8];
        pend = 0;
      end else if (in_clear) begin
        clear_left--;
        if (clear_left == 0) for (int k = 0; k < 64; k++) m_bytes[k] = 8'h00;
      end else if (ev && legal(mem_size, addr)) begin
        pend      = 1;
        pend_addr = addr;
        pend_size = mem_size;
        pend_data = data_i;
      end
      exp_busy = (clear_left > 0) || pend;
    end
  end

  logic last_err;
  int   n;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] s, input logic [31:0] a);
    mem_size = s;
    addr     = a;
    tick();
  endtask

  task automatic wr(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
    mem_size = s;
    addr     = a;
    data_i   = d;
    mem_clk  = 1'b1;
    tick();
    last_err = err;
    mem_clk  = 1'b0;
    tick();
  endtask

  task automatic count_busy();
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; mem_clk = 1'b0; mem_size = 2'b10; addr = 32'd0; data_i = 32'd0;
    r_reset = 1'b1; r_mem_clk = 1'b0; r_size = 2'b10; r_addr = 32'd0; r_data = 32'd0;
    tick();
    tick();
    check("rst_busy", busy, 1);
    check("rst_data", data_o, 0);
    check("rst_err", err, 0);

    reset = 1'b0;
    r_reset = 1'b0;
    count_busy();
    check("clear_len", n, 16);
    for (int a = 0; a < 64; a += 4) begin
      rd(2'b10, a);
      check("clear_word", data_o, 32'h0);
    end

    wr(2'b10, 32'h8, 32'hDEADBEEF);
    check("word_wr_err", last_err, 0);
    wr(2'b00, 32'h9, 32'h0000_0055);
    rd(2'b10, 32'h8);
    check("word_rd_8", data_o, 32'hDEAD55EF);
    rd(2'b01, 32'hA);
    check("half_rd_a", data_o, 32'h0000DEAD);
    rd(2'b00, 32'hB);
    check("byte_rd_b", data_o, 32'h0000_00DE);

    wr(2'b10, 32'h0, 32'h11223344);
    wr(2'b10, 32'h6, 32'hAAAAAAAA);
    check("rej_word_6", last_err, 1);
    wr(2'b01, 32'h3, 32'hBBBBBBBB);
    check("rej_half_3", last_err, 1);
    wr(2'b11, 32'h0, 32'hCCCCCCCC);
    check("rej_size3", last_err, 1);
    wr(2'b10, 32'h40, 32'hDDDDDDDD);
    check("rej_range", last_err, 1);
    rd(2'b10, 32'h0);
    check("keep_0", data_o, 32'h11223344);
    rd(2'b10, 32'h4);
    check("keep_4", data_o, 32'h0);
    rd(2'b10, 32'h8);
    check("keep_8", data_o, 32'hDEAD55EF);
    rd(2'b10, 32'h40);
    check("rd_range", data_o, 32'h0);

    mem_size = 2'b10; addr = 32'hC; data_i = 32'hCAFEF00D; mem_clk = 1'b1;
    tick();
    data_i = 32'hBAD0BAD0;
    repeat (4) tick();
    mem_clk = 1'b0;
    tick();
    rd(2'b10, 32'hC);
    check("hold_once", data_o, 32'hCAFEF00D);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    tick();
    mem_size = 2'b10; addr = 32'h0; data_i = 32'hFFFFFFFF; mem_clk = 1'b1;
    tick();
    check("clear_wr_err", err, 1);
    mem_clk = 1'b0;
    count_busy();
    check("clear_wr_idle", busy, 0);
    rd(2'b10, 32'h0);
    check("clear_wr_drop", data_o, 32'h0);

    mem_size = 2'b10; addr = 32'h4; data_i = 32'h12345678; mem_clk = 1'b1;
    tick();
    check("abort_in_write", busy, 1);
    reset = 1'b1;
    mem_clk = 1'b0;
    tick();
    reset = 1'b0;
    count_busy();
    check("abort_clear_len", n, 16);
    rd(2'b10, 32'h4);
    check("abort_rd_4", data_o, 32'h0);

    n = 0;
    while (r_busy && n < 1500) begin
      n++;
      tick();
    end
    check("big_clear_done", r_busy, 0);
    r_size = 2'b10; r_addr = 32'h0001_0000; r_data = 32'h77777777; r_mem_clk = 1'b1;
    tick();
    check("big_rej_err", r_err, 1);
    r_mem_clk = 1'b0;
    tick();
    check("big_rej_pulse", r_err, 0);
    check("big_rej_idle", r_busy, 0);
    check("big_rej_rd", r_data_o, 32'h0);
    tick();
    check("big_rd_noerr", r_err, 0);
    check("big_rd_zero", r_data_o, 32'h0);

    r_addr = 32'h0000_0FFC; r_data = 32'hA5A5A5A5; r_mem_clk = 1'b1;
    tick();
    check("big_wr_err", r_err, 0);
    check("big_wr_busy", r_busy, 1);
    r_mem_clk = 1'b0;
    tick();
    check("big_wr_n2", r_data_o, 32'h0);
    tick();
    check("big_wr_n3", r_data_o, 32'hA5A5A5A5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
